// File: rtl/clk_en_gen.sv
// Multi-channel fractional clock-enable generator. Strobes are derived from per-channel
// phase accumulators and run only after the PLL lock has been synchronised and settled.
module clk_en_gen #(
    parameter int                      NUM_CH    = 2,
    parameter int                      ACC_W     = 24,
    parameter int                      LOCK_WAIT = 1024,
    parameter logic [NUM_CH*ACC_W-1:0] INC_INIT  = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pll_locked,
    input  logic              cfg_we,
    input  logic [2:0]        cfg_ch,
    input  logic [ACC_W-1:0]  cfg_inc,
    input  logic              sync,
    output logic [NUM_CH-1:0] ce,
    output logic              ready
);

    localparam int CNT_W = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_WAIT - 1);

    localparam logic [1:0] S_WAIT_LOCK = 2'd0;
    localparam logic [1:0] S_SETTLE    = 2'd1;
    localparam logic [1:0] S_RUN       = 2'd2;

    logic              lk_meta_q;
    logic              lk_q;
    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [NUM_CH-1:0] ce_q, ce_d;
    logic              in_run;
    logic              run_en;

    // pll_locked is asynchronous to clk, so it is double-registered before any use.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lk_meta_q <= 1'b0;
            lk_q      <= 1'b0;
        end else begin
            lk_meta_q <= pll_locked;
            lk_q      <= lk_meta_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_WAIT_LOCK: begin
                if (lk_q) begin
                    state_d = S_SETTLE;
                    cnt_d   = '0;
                end
            end
            S_SETTLE: begin
                if (!lk_q) begin
                    state_d = S_WAIT_LOCK;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_RUN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RUN: begin
                if (!lk_q) begin
                    state_d = S_WAIT_LOCK;
                end
            end
            default: state_d = S_WAIT_LOCK;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_WAIT_LOCK;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_run = (state_q == S_RUN);
    // A RUN cycle that sees lk low is the one leaving RUN: it already clears the channels.
    assign run_en = in_run && lk_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [ACC_W-1:0] acc_q, acc_d;
        logic [ACC_W-1:0] inc_a_q, inc_a_d;
        logic [ACC_W-1:0] inc_s_q, inc_s_d;
        logic [ACC_W:0]   sum;
        logic             wr_hit;
        logic             carry;

        // The shadow is promoted on a strobe so a rate change lands on a strobe boundary;
        // an idle or stopped channel has no boundary to wait for and takes it at once.
        always_comb begin
            wr_hit  = cfg_we && (cfg_ch == 3'(i));
            sum     = {1'b0, acc_q} + {1'b0, inc_a_q};
            carry   = run_en && !sync && sum[ACC_W];
            inc_s_d = wr_hit ? cfg_inc : inc_s_q;
            inc_a_d = inc_a_q;
            if (!in_run || (inc_a_q == '0) || carry) begin
                inc_a_d = inc_s_d;
            end
            acc_d = (run_en && !sync) ? sum[ACC_W-1:0] : '0;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                acc_q   <= '0;
                inc_a_q <= INC_INIT[i*ACC_W +: ACC_W];
                inc_s_q <= INC_INIT[i*ACC_W +: ACC_W];
            end else begin
                acc_q   <= acc_d;
                inc_a_q <= inc_a_d;
                inc_s_q <= inc_s_d;
            end
        end

        assign ce_d[i] = carry;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ce_q <= '0;
        end else begin
            ce_q <= ce_d;
        end
    end

    assign ce    = ce_q;
    assign ready = in_run;

endmodule

// File: tb/tb_clk_en_gen.sv
// Self-checking bench for clk_en_gen: directed lock/rate/sync/reset scenarios plus
// randomized traffic compared every cycle against a behavioural model.
module tb_clk_en_gen;

    localparam int NUM_CH    = 2;
    localparam int ACC_W     = 8;
    localparam int LOCK_WAIT = 4;
    localparam logic [NUM_CH*ACC_W-1:0] INC_INIT = {8'h60, 8'h80};
    localparam int FULL = 1 << ACC_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              pll_locked = 1'b0;
    logic              cfg_we = 1'b0;
    logic [2:0]        cfg_ch = 3'd0;
    logic [ACC_W-1:0]  cfg_inc = '0;
    logic              sync = 1'b0;
    logic [NUM_CH-1:0] ce;
    logic              ready;

    int numCompared = 0;
    int numMismatched = 0;

    clk_en_gen #(
        .NUM_CH   (NUM_CH),
        .ACC_W    (ACC_W),
        .LOCK_WAIT(LOCK_WAIT),
        .INC_INIT (INC_INIT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pll_locked(pll_locked),
        .cfg_we    (cfg_we),
        .cfg_ch    (cfg_ch),
        .cfg_inc   (cfg_inc),
        .sync      (sync),
        .ce        (ce),
        .ready     (ready)
    );

    always #5 clk = ~clk;

    // Behavioural model: lock is "good" once the synchronised lock has been seen high
    // on LOCK_WAIT+1 consecutive edges; channels are plain integer phase accumulators.
    int mMeta, mLk, mStreak, mReady;
    int mAcc [NUM_CH];
    int mIncA[NUM_CH];
    int mIncS[NUM_CH];
    int mCe  [NUM_CH];
    int mSum, mNewS, mStrobe, mRunning;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mMeta = 0; mLk = 0; mStreak = 0; mReady = 0;
            for (int i = 0; i < NUM_CH; i++) begin
                mAcc[i]  = 0;
                mCe[i]   = 0;
                mIncA[i] = int'(INC_INIT[i*ACC_W +: ACC_W]);
                mIncS[i] = mIncA[i];
            end
        end else begin
            mRunning = (mReady != 0 && mLk != 0) ? 1 : 0;
            for (int i = 0; i < NUM_CH; i++) begin
                mSum    = mAcc[i] + mIncA[i];
                mNewS   = (cfg_we && int'(cfg_ch) == i) ? int'(cfg_inc) : mIncS[i];
                mStrobe = (mRunning != 0 && !sync && mSum >= FULL) ? 1 : 0;
                mAcc[i] = (mRunning != 0 && !sync) ? (mSum % FULL) : 0;
                mCe[i]  = mStrobe;
                if (mReady == 0 || mIncA[i] == 0 || mStrobe != 0) mIncA[i] = mNewS;
                mIncS[i] = mNewS;
            end
            if (mLk != 0) mStreak = (mStreak < LOCK_WAIT + 1) ? mStreak + 1 : mStreak;
            else          mStreak = 0;
            mReady = (mStreak >= LOCK_WAIT + 1) ? 1 : 0;
            mLk    = mMeta;
            mMeta  = int'(pll_locked);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        numCompared++;
        if (act !== exp) begin
            numMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    logic [NUM_CH-1:0] mCeVec;

    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CH; i++) mCeVec[i] = (mCe[i] != 0);
            checkOutput("model_ce", 32'(ce), 32'(mCeVec));
            checkOutput("model_ready", 32'(ready), 32'(mReady));
        end
    end

    task automatic countEdgesUntil(input logic want, output int n);
        n = 0;
        while (n < 40) begin
            @(posedge clk); #1;
            n++;
            if (ready === want) break;
        end
    endtask

    task automatic sampleCe(input int n, output int m0, output int m1);
        m0 = 0; m1 = 0;
        for (int k = 1; k <= n; k++) begin
            @(posedge clk); #1;
            m0 |= int'(ce[0]) << k;
            m1 |= int'(ce[1]) << k;
        end
    endtask

    int lockLow = 0;

    task automatic applyStimulus();
        cfg_we = ($urandom_range(0, 3) == 0);
        cfg_ch = 3'($urandom_range(0, 7));
        case ($urandom_range(0, 3))
            0:       cfg_inc = '0;
            1:       cfg_inc = 8'($urandom_range(128, 255));
            default: cfg_inc = 8'($urandom_range(1, 127));
        endcase
        sync = ($urandom_range(0, 15) == 0);
        if (lockLow > 0) begin
            lockLow--;
            if (lockLow == 0) pll_locked = 1'b1;
        end else if ($urandom_range(0, 299) == 0) begin
            pll_locked = 1'b0;
            lockLow = $urandom_range(1, 12);
        end
        @(negedge clk);
    endtask

    int n, nFall, m0, m1, found;

    initial begin
        repeat (3) @(negedge clk);
        checkOutput("reset_ready", 32'(ready), 32'd0);
        checkOutput("reset_ce", 32'(ce), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        pll_locked = 1'b1;
        countEdgesUntil(1'b1, n);
        checkOutput("lock_to_ready_edges", n, 7);
        sampleCe(8, m0, m1);
        checkOutput("ce0_rate_0x80", m0, 'h154);
        checkOutput("ce1_rate_0x60", m1, 'h148);

        // Move both channels to 0x40; they land on their own strobes with different phases.
        @(negedge clk); cfg_we = 1'b1; cfg_ch = 3'd0; cfg_inc = 8'h40;
        @(negedge clk); cfg_ch = 3'd1;
        @(negedge clk); cfg_we = 1'b0;
        repeat (20) @(negedge clk);

        found = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (ce[0]) begin found = 1; break; end
        end
        checkOutput("ch0_strobe_found", found, 1);
        repeat (3) @(posedge clk);
        @(negedge clk); sync = 1'b1;
        @(posedge clk); #1;
        checkOutput("sync_edge_ce", 32'(ce), 32'd0);
        @(negedge clk); sync = 1'b0;
        sampleCe(4, m0, m1);
        checkOutput("sync_ce0_after4", m0, 'h10);
        checkOutput("sync_ce1_aligned", m1, 'h10);

        @(posedge clk);
        @(negedge clk); cfg_we = 1'b1; cfg_ch = 3'd0; cfg_inc = 8'h80;
        m0 = 0; m1 = 0;
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk); #1;
            m0 |= int'(ce[0]) << k;
            m1 |= int'(ce[1]) << k;
            @(negedge clk);
            if (k == 1) begin cfg_ch = 3'd5; cfg_inc = 8'hFF; end
            else cfg_we = 1'b0;
        end
        checkOutput("rate_change_ce0", m0, 'hA8);
        checkOutput("bad_channel_ignored_ce1", m1, 'h88);

        pll_locked = 1'b0;
        @(posedge clk); #1;
        nFall = 1;
        @(negedge clk); pll_locked = 1'b1;
        countEdgesUntil(1'b0, n);
        nFall += n;
        checkOutput("lock_loss_edges", nFall, 3);
        countEdgesUntil(1'b1, n);
        checkOutput("relock_edges", nFall + n, 8);
        sampleCe(8, m0, m1);
        checkOutput("retained_ce0", m0, 'h154);
        checkOutput("retained_ce1", m1, 'h110);

        #2 rst = 1'b1;
        #1;
        checkOutput("async_rst_ready", 32'(ready), 32'd0);
        checkOutput("async_rst_ce", 32'(ce), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        countEdgesUntil(1'b1, n);
        checkOutput("relock_after_rst", n, 7);
        sampleCe(8, m0, m1);
        checkOutput("init_restored_ce0", m0, 'h154);
        checkOutput("init_restored_ce1", m1, 'h148);

        @(negedge clk);
        for (int c = 0; c < 3000; c++) applyStimulus();
        cfg_we = 1'b0;
        sync = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
        $finish;
    end

endmodule
